// File: rtl/can_reg_arb_pkg.sv
// Shared types and constants for the SJA1000-FD register-port arbiter.
package can_reg_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Width of a counter that must hold 0..lock_max inclusive.
  function automatic int lock_cnt_w(input int lock_max);
    return $clog2(lock_max + 1);
  endfunction

endpackage

// File: rtl/can_rr_arbiter.sv
// Rotating-priority picker: the first requester at or above the pointer
// (with wrap) wins. Purely combinational, one-hot result.
module can_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             any_o
);

  // Walk offsets from the pointer; exactly one port matches each offset.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!any_o && req_i[i] && (((int'(ptr_i) + k) % N_REQ) == i)) begin
          grant_o[i] = 1'b1;
          any_o      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/can_reg_arbiter.sv
// Arbitrates the 8-bit core register port between N_REQ requesters.
// One access at a time: IDLE -> ISSUE -> DONE -> GAP -> IDLE, with optional
// locked bursts bounded by LOCK_MAX consecutive grants.
module can_reg_arbiter
  import can_reg_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int GAP_CYCLES = 1,
  parameter int LOCK_MAX   = 16
) (
  input  logic                      aclk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ-1:0]          req_write_i,
  input  logic [N_REQ-1:0]          req_lock_i,
  input  logic [ADDR_W*N_REQ-1:0]   req_addr_i,
  input  logic [DATA_W*N_REQ-1:0]   req_wdata_i,
  output logic [N_REQ-1:0]          req_done_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic [N_REQ-1:0]          grant_o,
  output logic                      busy_o,
  output logic                      reg_re_o,
  output logic                      reg_we_o,
  output logic [ADDR_W-1:0]         reg_addr_read_o,
  output logic [ADDR_W-1:0]         reg_addr_write_o,
  output logic [DATA_W-1:0]         reg_data_in_o,
  input  logic [DATA_W-1:0]         reg_data_out_i
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LCW   = lock_cnt_w(LOCK_MAX);
  localparam int GW    = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [LCW-1:0]   LOCK_MAX_C = LCW'(LOCK_MAX);
  localparam logic [GW-1:0]    GAP_LOAD   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PTR_W-1:0] LAST_PORT  = PTR_W'(N_REQ - 1);

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [LCW-1:0]     r_lock_cnt;
  logic               r_lock_pend;
  logic               r_write;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   r_done;
  logic [GW-1:0]      r_gap_cnt;

  logic [N_REQ-1:0]   w_rr_grant;
  logic               w_rr_any;
  logic               w_lock_win;
  logic [N_REQ-1:0]   w_win_oh;
  logic               w_any;
  logic [PTR_W-1:0]   w_win_idx;
  logic               w_win_write;
  logic               w_win_lock;
  logic [ADDR_W-1:0]  w_win_addr;
  logic [DATA_W-1:0]  w_win_wdata;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [LCW-1:0]     w_next_lock_cnt;

  can_rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i   (req_valid_i),
    .ptr_i   (r_ptr),
    .grant_o (w_rr_grant),
    .any_o   (w_rr_any)
  );

  // A locked owner keeps the port while it still wants it and has budget left.
  assign w_lock_win = r_lock_pend && (r_lock_cnt < LOCK_MAX_C) && req_valid_i[r_owner];
  assign w_win_oh   = w_lock_win ? (N_REQ'(1) << r_owner) : w_rr_grant;
  assign w_any      = w_lock_win || w_rr_any;

  // Encode the winner and mux out its request fields.
  always_comb begin
    w_win_idx   = '0;
    w_win_write = 1'b0;
    w_win_lock  = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win_oh[i]) begin
        w_win_idx   = PTR_W'(i);
        w_win_write = req_write_i[i];
        w_win_lock  = req_lock_i[i];
        w_win_addr  = req_addr_i[ADDR_W*i +: ADDR_W];
        w_win_wdata = req_wdata_i[DATA_W*i +: DATA_W];
      end
    end
  end

  assign w_next_ptr = (w_win_idx == LAST_PORT) ? '0 : w_win_idx + 1'b1;

  // A grant requested with lock counts toward the burst: it starts at 1 and
  // extends only when it continues the previous owner's lock.
  always_comb begin
    w_next_lock_cnt = '0;
    if (w_win_lock) begin
      w_next_lock_cnt = w_lock_win ? r_lock_cnt + 1'b1 : LCW'(1);
    end
  end

  // Access sequencer: capture on grant, strobe, report, then idle gap.
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_lock_cnt  <= '0;
      r_lock_pend <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_gap_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state     <= ISSUE;
            r_grant     <= w_win_oh;
            r_owner     <= w_win_idx;
            r_write     <= w_win_write;
            r_addr      <= w_win_addr;
            r_wdata     <= w_win_wdata;
            r_ptr       <= w_next_ptr;
            r_lock_cnt  <= w_next_lock_cnt;
            r_lock_pend <= 1'b0;
          end else if (!req_valid_i[r_owner]) begin
            r_lock_pend <= 1'b0;
            r_lock_cnt  <= '0;
          end
        end
        ISSUE: begin
          r_state <= DONE;
          r_done  <= r_grant;
          r_rdata <= r_write ? '0 : reg_data_out_i;
        end
        DONE: begin
          r_done      <= '0;
          r_rdata     <= '0;
          r_grant     <= '0;
          r_lock_pend <= req_lock_i[r_owner] && req_valid_i[r_owner];
          if (!req_lock_i[r_owner] || !req_valid_i[r_owner]) begin
            r_lock_cnt <= '0;
          end
          r_gap_cnt <= GAP_LOAD;
          r_state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
        end
        GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign reg_re_o         = (r_state == ISSUE) && !r_write;
  assign reg_we_o         = (r_state == ISSUE) && r_write;
  assign reg_addr_read_o  = r_addr;
  assign reg_addr_write_o = r_addr;
  assign reg_data_in_o    = r_wdata;
  assign busy_o           = (r_state != IDLE);
  assign grant_o          = r_grant;
  assign req_done_o       = r_done;
  assign rsp_rdata_o      = r_rdata;

endmodule

// File: tb/tb_can_reg_arbiter.sv
// Bench for can_reg_arbiter: a default instance checked against a
// scoreboard, plus instances with LOCK_MAX=4, GAP_CYCLES=0 and GAP_CYCLES=3.
module tb_can_reg_arbiter;

  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic [N-1:0]   req_valid, req_write, req_lock;
  logic [8*N-1:0] req_addr, req_wdata;

  logic [N-1:0] m_done, m_grant, l_done, l_grant, z_done, z_grant, t_done, t_grant;
  logic [7:0]   m_rdata, m_ara, m_awa, m_din, m_dout;
  logic [7:0]   l_rdata, l_ara, l_awa, l_din, l_dout;
  logic [7:0]   z_rdata, z_ara, z_awa, z_din, z_dout;
  logic [7:0]   t_rdata, t_ara, t_awa, t_din, t_dout;
  logic         m_busy, m_re, m_we, l_busy, l_re, l_we;
  logic         z_busy, z_re, z_we, t_busy, t_re, t_we;

  // Core register file model: read data is a fixed function of the address.
  function automatic logic [7:0] core_rd(input logic [7:0] a);
    return a ^ 8'h58;
  endfunction

  assign m_dout = core_rd(m_ara);
  assign l_dout = core_rd(l_ara);
  assign z_dout = core_rd(z_ara);
  assign t_dout = core_rd(t_ara);

  can_reg_arbiter #(.N_REQ(N), .GAP_CYCLES(1), .LOCK_MAX(16)) u_main (
    .aclk(clk), .rst(rst), .req_valid_i(req_valid), .req_write_i(req_write),
    .req_lock_i(req_lock), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_done_o(m_done), .rsp_rdata_o(m_rdata), .grant_o(m_grant), .busy_o(m_busy),
    .reg_re_o(m_re), .reg_we_o(m_we), .reg_addr_read_o(m_ara), .reg_addr_write_o(m_awa),
    .reg_data_in_o(m_din), .reg_data_out_i(m_dout));

  can_reg_arbiter #(.N_REQ(N), .GAP_CYCLES(1), .LOCK_MAX(4)) u_lk (
    .aclk(clk), .rst(rst), .req_valid_i(req_valid), .req_write_i(req_write),
    .req_lock_i(req_lock), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_done_o(l_done), .rsp_rdata_o(l_rdata), .grant_o(l_grant), .busy_o(l_busy),
    .reg_re_o(l_re), .reg_we_o(l_we), .reg_addr_read_o(l_ara), .reg_addr_write_o(l_awa),
    .reg_data_in_o(l_din), .reg_data_out_i(l_dout));

  can_reg_arbiter #(.N_REQ(N), .GAP_CYCLES(0), .LOCK_MAX(16)) u_g0 (
    .aclk(clk), .rst(rst), .req_valid_i(req_valid), .req_write_i(req_write),
    .req_lock_i(req_lock), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_done_o(z_done), .rsp_rdata_o(z_rdata), .grant_o(z_grant), .busy_o(z_busy),
    .reg_re_o(z_re), .reg_we_o(z_we), .reg_addr_read_o(z_ara), .reg_addr_write_o(z_awa),
    .reg_data_in_o(z_din), .reg_data_out_i(z_dout));

  can_reg_arbiter #(.N_REQ(N), .GAP_CYCLES(3), .LOCK_MAX(16)) u_g3 (
    .aclk(clk), .rst(rst), .req_valid_i(req_valid), .req_write_i(req_write),
    .req_lock_i(req_lock), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_done_o(t_done), .rsp_rdata_o(t_rdata), .grant_o(t_grant), .busy_o(t_busy),
    .reg_re_o(t_re), .reg_we_o(t_we), .reg_addr_read_o(t_ara), .reg_addr_write_o(t_awa),
    .reg_data_in_o(t_din), .reg_data_out_i(t_dout));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         owner;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   done_times[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   strobe_cnt = 0;
  bit   mon_en = 1'b0;

  task automatic push_exp(input int owner, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata);
    exp_t e;
    e.owner = owner; e.wr = wr; e.addr = addr; e.wdata = wdata;
    sb.push_back(e);
  endtask

  // Scoreboard on u_main: every strobe and done must match the queue head.
  task automatic scoreboard_monitor();
    exp_t       e;
    logic [N-1:0] oh;
    logic [7:0] rd_exp;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (m_re || m_we) begin
          strobe_cnt++;
          n_chk++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_strobe: got access addr=%h we=%b, required none", m_ara, m_we);
          end else begin
            e = sb[0]; oh = '0; oh[e.owner] = 1'b1;
            n_chk++;
            if ({m_we, m_re, m_ara, m_awa, m_grant} !== {e.wr, !e.wr, e.addr, e.addr, oh}) begin
              n_bad++;
              $display("FAIL sb_access: got we=%b re=%b ra=%h wa=%h grant=%b, required we=%b ra=wa=%h grant=%b",
                       m_we, m_re, m_ara, m_awa, m_grant, e.wr, e.addr, oh);
            end
            if (e.wr) begin
              n_chk++;
              if (m_din !== e.wdata) begin
                n_bad++;
                $display("FAIL sb_wdata: got %h required %h", m_din, e.wdata);
              end
            end
          end
        end else if (m_done !== '0) begin
          n_chk++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_done: got done=%b, required none", m_done);
          end else begin
            e = sb.pop_front(); oh = '0; oh[e.owner] = 1'b1;
            rd_exp = e.wr ? 8'h00 : core_rd(e.addr);
            n_chk++;
            if ({m_done, m_rdata} !== {oh, rd_exp}) begin
              n_bad++;
              $display("FAIL sb_done_data: got done=%b rdata=%h required done=%b rdata=%h",
                       m_done, m_rdata, oh, rd_exp);
            end
            $display("txn owner=%0d wr=%b addr=%h rdata=%h cyc=%0d", e.owner, e.wr, e.addr, m_rdata, cyc);
          end
          done_cnt++;
          done_times.push_back(cyc);
        end else if (m_busy) begin
          n_chk++;
          if (m_grant !== '0) begin
            n_bad++;
            $display("FAIL gap_grant: got %b required 00", m_grant);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    sb.delete(); done_times.delete();
    done_cnt = 0; strobe_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11; req_write = '0; req_lock = '0; req_addr = 16'h0102; req_wdata = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({m_done, m_grant, m_rdata, m_busy, m_re, m_we, m_ara, m_awa, m_din} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got done=%b grant=%b rdata=%h busy=%b re=%b we=%b addr=%h din=%h, required all 0",
               m_done, m_grant, m_rdata, m_busy, m_re, m_we, m_ara, m_din);
    end
    n_chk++;
    if ({z_busy, z_grant, t_busy, t_grant, l_busy, l_grant} !== '0) begin
      n_bad++;
      $display("FAIL reset_other: got busy/grant not 0 (z=%b/%b t=%b/%b l=%b/%b)",
               z_busy, z_grant, t_busy, t_grant, l_busy, l_grant);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    mon_en = 1'b1;
    push_exp(0, 1'b0, 8'h02, 8'h00);
    @(negedge clk); #1;
    req_addr[7:0] = 8'h02; req_valid[0] = 1'b1;
    @(negedge clk); #1;
    n_chk++;
    if ({m_re, m_we, m_ara} !== {1'b1, 1'b0, 8'h02}) begin
      n_bad++;
      $display("FAIL read_strobe: got re=%b we=%b addr=%h required re=1 we=0 addr=02", m_re, m_we, m_ara);
    end
    @(negedge clk); #1;
    n_chk++;
    if ({m_done, m_rdata} !== {2'b01, 8'h5A}) begin
      n_bad++;
      $display("FAIL read_done: got done=%b rdata=%h required done=01 rdata=5a", m_done, m_rdata);
    end
    req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (m_busy !== 1'b0 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL read_idle: got busy=%b pending=%0d required busy=0 pending=0", m_busy, sb.size());
    end
  endtask

  task automatic test_contention();
    do_reset();
    mon_en = 1'b1;
    for (int k = 0; k < 4; k++) push_exp(k % 2, 1'b0, (k % 2 == 1) ? 8'h21 : 8'h20, 8'h00);
    @(negedge clk); #1;
    req_addr = 16'h2120; req_valid = 2'b11;
    for (int c = 0; c < 60 && done_cnt < 4; c++) begin
      @(negedge clk); #1;
    end
    req_valid = '0;
    n_chk++;
    if (done_cnt != 4) begin
      n_bad++;
      $display("FAIL contention_count: got %0d dones required 4", done_cnt);
    end
    for (int i = 1; i < done_times.size(); i++) begin
      n_chk++;
      if (done_times[i] - done_times[i-1] != 4) begin
        n_bad++;
        $display("FAIL contention_spacing: got %0d cycles required 4", done_times[i] - done_times[i-1]);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_lock_burst();
    do_reset();
    mon_en = 1'b1;
    for (int k = 0; k < 13; k++) push_exp(1, 1'b0, 8'h10 + 8'(k), 8'h00);
    push_exp(0, 1'b0, 8'h30, 8'h00);
    @(negedge clk); #1;
    req_addr = 16'h1030; req_lock[1] = 1'b1; req_valid[1] = 1'b1;
    for (int c = 0; c < 150 && done_cnt < 14; c++) begin
      @(negedge clk); #1;
      if (strobe_cnt >= 1) req_valid[0] = 1'b1;
      if (strobe_cnt >= 13) req_lock[1] = 1'b0;
      if (done_cnt >= 13) req_valid[1] = 1'b0;
      else req_addr[15:8] = 8'h10 + done_cnt[7:0];
    end
    req_valid = '0; req_lock = '0;
    n_chk++;
    if (done_cnt != 14) begin
      n_bad++;
      $display("FAIL lock_burst_count: got %0d dones required 14", done_cnt);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_lock_max();
    int owners[$];
    int exp_o[10];
    exp_o = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    mon_en = 1'b0;
    do_reset();
    @(negedge clk); #1;
    req_addr = 16'h6160; req_lock[1] = 1'b1; req_valid[1] = 1'b1;
    for (int c = 0; c < 150 && owners.size() < 10; c++) begin
      @(negedge clk); #1;
      if (l_grant != '0) req_valid[0] = 1'b1;
      if (l_done != '0) owners.push_back(l_done[1] ? 1 : 0);
    end
    req_valid = '0; req_lock = '0;
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (i >= owners.size()) begin
        n_bad++;
        $display("FAIL lock_max_seq[%0d]: got no grant required owner %0d", i, exp_o[i]);
      end else if (owners[i] != exp_o[i]) begin
        n_bad++;
        $display("FAIL lock_max_seq[%0d]: got owner %0d required %0d", i, owners[i], exp_o[i]);
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_write();
    int we_cycles = 0;
    do_reset();
    mon_en = 1'b1;
    push_exp(1, 1'b1, 8'h06, 8'hC3);
    @(negedge clk); #1;
    req_addr[15:8] = 8'h06; req_wdata[15:8] = 8'hC3; req_write[1] = 1'b1; req_valid[1] = 1'b1;
    for (int c = 0; c < 20 && done_cnt < 1; c++) begin
      @(negedge clk); #1;
      if (m_we) we_cycles++;
    end
    req_valid = '0; req_write = '0;
    n_chk++;
    if (we_cycles != 1 || done_cnt != 1) begin
      n_bad++;
      $display("FAIL write_strobe: got we_cycles=%0d dones=%0d required 1 and 1", we_cycles, done_cnt);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_gap_spacing();
    int zs[$];
    int ts[$];
    mon_en = 1'b0;
    do_reset();
    @(negedge clk); #1;
    req_addr[7:0] = 8'h40; req_valid[0] = 1'b1;
    for (int c = 0; c < 60 && (zs.size() < 3 || ts.size() < 3); c++) begin
      @(negedge clk); #1;
      if (z_re) zs.push_back(cyc);
      if (t_re) ts.push_back(cyc);
    end
    req_valid = '0;
    for (int i = 1; i < 3; i++) begin
      n_chk++;
      if (i >= zs.size() || zs[i] - zs[i-1] != 3) begin
        n_bad++;
        $display("FAIL gap0_spacing[%0d]: got %0d strobes/spacing wrong required 3", i, zs.size());
      end
      n_chk++;
      if (i >= ts.size() || ts[i] - ts[i-1] != 6) begin
        n_bad++;
        $display("FAIL gap3_spacing[%0d]: got %0d strobes/spacing wrong required 6", i, ts.size());
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_in_issue();
    do_reset();
    mon_en = 1'b1;
    push_exp(0, 1'b0, 8'h50, 8'h00);
    @(negedge clk); #1;
    req_addr = 16'h5150; req_valid = 2'b11;
    for (int c = 0; c < 10 && strobe_cnt < 1; c++) begin
      @(negedge clk); #1;
    end
    n_chk++;
    if (strobe_cnt != 1) begin
      n_bad++;
      $display("FAIL rst_issue_setup: got %0d strobes required 1", strobe_cnt);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    n_chk++;
    if ({m_done, m_grant, m_rdata, m_busy, m_re, m_we, m_ara, m_din} !== '0) begin
      n_bad++;
      $display("FAIL rst_issue_outputs: got done=%b grant=%b busy=%b re=%b addr=%h required all 0",
               m_done, m_grant, m_busy, m_re, m_ara);
    end
    sb.delete(); done_times.delete(); done_cnt = 0; strobe_cnt = 0;
    push_exp(0, 1'b0, 8'h50, 8'h00);
    push_exp(1, 1'b0, 8'h51, 8'h00);
    rst = 1'b0;
    for (int c = 0; c < 40 && done_cnt < 2; c++) begin
      @(negedge clk); #1;
    end
    req_valid = '0;
    n_chk++;
    if (done_cnt != 2) begin
      n_bad++;
      $display("FAIL rst_issue_regrant: got %0d dones required 2", done_cnt);
    end
    repeat (4) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL rst_issue_pending: got %0d pending required 0", sb.size());
    end
  endtask

  initial begin
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_single_read();
    test_contention();
    test_lock_burst();
    test_lock_max();
    test_write();
    test_gap_spacing();
    test_reset_in_issue();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 required earlier finish");
    $fatal(1, "watchdog");
  end

endmodule
